// File: rtl/led_bank.sv
// led_bank: CPU-written LED pattern with per-LED hardware blink; optional global PWM dimmer under LED_BANK_PWM_EN.
// Latency: a register write reaches ledout one led_clk cycle later; ledrdata is combinational.
// Backpressure: none; every strobed write is taken on the falling edge where it is presented.
module led_bank #(
   parameter int LED_W = 16,
   parameter int DIV_W = 24
) (
   input  logic             led_clk,
   input  logic             ledrst,
   input  logic             ledctrl,
   input  logic [1:0]       ledaddr,
   input  logic [3:0]       ledbe,
   input  logic [31:0]      ledwdata,
   output logic [31:0]      ledrdata,
   output logic [LED_W-1:0] ledout
);

   logic [LED_W-1:0] data_q, mask_q, data_nx, mask_nx, lit;
   logic [DIV_W-1:0] period_q, period_nx, cnt_q;
   logic             phase_q, dim;
   logic             wr_data, wr_mask, wr_period;

   // Byte-lane merge on a 32-bit view; lanes above the register width fall off in the cast.
   function automatic logic [31:0] merge_bytes(input logic [31:0] cur, input logic [31:0] wd,
                                               input logic [3:0] be);
      logic [31:0] res;
      res = cur;
      for (int k = 0; k < 4; k++)
         if (be[k]) res[8*k +: 8] = wd[8*k +: 8];
      return res;
   endfunction

   assign wr_data   = ledctrl && (ledaddr == 2'd0);
   assign wr_mask   = ledctrl && (ledaddr == 2'd1);
   assign wr_period = ledctrl && (ledaddr == 2'd2);

   assign data_nx   = LED_W'(merge_bytes(32'(data_q), ledwdata, ledbe));
   assign mask_nx   = LED_W'(merge_bytes(32'(mask_q), ledwdata, ledbe));
   assign period_nx = DIV_W'(merge_bytes(32'(period_q), ledwdata, ledbe));

`ifdef LED_BANK_PWM_EN
   logic [7:0] bright_q, pwm_cnt_q;
   logic       wr_bright;

   assign wr_bright = ledctrl && (ledaddr == 2'd3);
   assign dim       = (bright_q == 8'hFF) || (pwm_cnt_q < bright_q);

   always_ff @(negedge led_clk) begin
      if (!ledrst) begin
         bright_q  <= 8'hFF;
         pwm_cnt_q <= 8'h00;
      end else begin
         if (wr_bright) bright_q <= 8'(merge_bytes(32'(bright_q), ledwdata, ledbe));
         pwm_cnt_q <= pwm_cnt_q + 8'd1;
      end
   end
`else
   assign dim = 1'b1;
`endif

   assign lit = data_q & (~mask_q | {LED_W{phase_q}}) & {LED_W{dim}};

   always_ff @(negedge led_clk) begin
      if (!ledrst) begin
         data_q   <= '0;
         mask_q   <= '0;
         period_q <= '0;
         cnt_q    <= '0;
         phase_q  <= 1'b1;
         ledout   <= '0;
      end else begin
         if (wr_data)   data_q   <= data_nx;
         if (wr_mask)   mask_q   <= mask_nx;
         if (wr_period) period_q <= period_nx;
         // A PERIOD write restarts the blink and beats a coincident wrap.
         if (wr_period || (period_q == '0)) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
         end else if (cnt_q == period_q - DIV_W'(1)) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
         end else begin
            cnt_q <= cnt_q + DIV_W'(1);
         end
         ledout <= lit;
      end
   end

   always_comb begin
      ledrdata = 32'h0;
      case (ledaddr)
         2'd0: ledrdata = 32'(data_q);
         2'd1: ledrdata = 32'(mask_q);
         2'd2: ledrdata = 32'(period_q);
`ifdef LED_BANK_PWM_EN
         2'd3: ledrdata = 32'(bright_q);
`else
         2'd3: ledrdata = 32'h0;
`endif
         default: ledrdata = 32'h0;
      endcase
   end

endmodule
